// File: rtl/prog_loader_pkg.sv
// Shared types and defaults for the program loader and the core top level
// that consumes its instruction-memory write port.
package prog_loader_pkg;

  localparam int unsigned PL_IW    = 9;
  localparam int unsigned PL_AW    = 6;
  localparam int unsigned PL_DEPTH = 64;

  localparam logic [PL_IW-1:0] PL_FILL_WORD = 9'h000;

  typedef enum logic [1:0] {
    IDLE,
    LOAD,
    FILL,
    DONE
  } loader_state_t;

endpackage

// File: rtl/prog_loader.sv
// Streams machine-code words into instruction memory while holding the core in reset,
// optionally pads the remainder with a fill word, then releases the core.
module prog_loader
  import prog_loader_pkg::*;
#(
  parameter int unsigned    IW        = PL_IW,
  parameter int unsigned    AW        = PL_AW,
  parameter int unsigned    DEPTH     = PL_DEPTH,
  parameter bit             FILL_EN   = 1'b1,
  parameter logic [IW-1:0]  FILL_WORD = IW'(PL_FILL_WORD)
) (
  input  logic          Clk,
  input  logic          Reset,
  input  logic          start,
  input  logic          in_valid,
  input  logic [IW-1:0] in_word,
  input  logic          in_last,
  output logic          in_ready,
  output logic          wr_en,
  output logic [AW-1:0] wr_addr,
  output logic [IW-1:0] wr_data,
  output logic          core_reset,
  output logic          loaded,
  output logic [AW:0]   word_count,
  output logic          overflow
);

  localparam logic [AW-1:0] LastAddr = AW'(DEPTH - 1);
  localparam logic [AW-1:0] AddrOne  = AW'(1);
  localparam logic [AW:0]   CntOne   = (AW + 1)'(1);

  loader_state_t r_state;
  logic [AW-1:0] r_addr;
  logic          r_wr_en;
  logic [AW-1:0] r_wr_addr;
  logic [IW-1:0] r_wr_data;
  logic          r_core_reset;
  logic          r_loaded;
  logic [AW:0]   r_word_count;
  logic          r_overflow;

  logic w_in_ready;
  logic w_hs;
  logic w_at_end;
  logic w_go_fill;

  always_comb begin
    w_in_ready = (r_state == LOAD);
    w_hs       = in_valid & w_in_ready;
    w_at_end   = (r_addr == LastAddr);
    w_go_fill  = FILL_EN & in_last & ~w_at_end;
  end

  always_ff @(posedge Clk or posedge Reset) begin
    if (Reset) begin
      r_state      <= IDLE;
      r_addr       <= '0;
      r_wr_en      <= 1'b0;
      r_wr_addr    <= '0;
      r_wr_data    <= '0;
      r_core_reset <= 1'b1;
      r_loaded     <= 1'b0;
      r_word_count <= '0;
      r_overflow   <= 1'b0;
    end else begin
      r_wr_en <= 1'b0;
      unique case (r_state)
        IDLE: begin
          if (start) begin
            r_state      <= LOAD;
            r_addr       <= '0;
            r_word_count <= '0;
            r_overflow   <= 1'b0;
          end
        end
        LOAD: begin
          if (w_hs) begin
            r_wr_en      <= 1'b1;
            r_wr_addr    <= r_addr;
            r_wr_data    <= in_word;
            r_word_count <= r_word_count + CntOne;
            // Address saturates at the last location; leaving LOAD is forced there.
            if (!w_at_end) begin
              r_addr <= r_addr + AddrOne;
            end
            if (in_last || w_at_end) begin
              r_state    <= w_go_fill ? FILL : DONE;
              r_overflow <= ~in_last;
            end
          end
        end
        FILL: begin
          r_wr_en   <= 1'b1;
          r_wr_addr <= r_addr;
          r_wr_data <= FILL_WORD;
          if (w_at_end) begin
            r_state <= DONE;
          end else begin
            r_addr <= r_addr + AddrOne;
          end
        end
        DONE: begin
          // Release lags entry by one cycle so the final write lands before fetch.
          if (start) begin
            r_state      <= LOAD;
            r_addr       <= '0;
            r_word_count <= '0;
            r_overflow   <= 1'b0;
            r_core_reset <= 1'b1;
            r_loaded     <= 1'b0;
          end else begin
            r_core_reset <= 1'b0;
            r_loaded     <= 1'b1;
          end
        end
        default: r_state <= IDLE;
      endcase
    end
  end

  assign in_ready   = w_in_ready;
  assign wr_en      = r_wr_en;
  assign wr_addr    = r_wr_addr;
  assign wr_data    = r_wr_data;
  assign core_reset = r_core_reset;
  assign loaded     = r_loaded;
  assign word_count = r_word_count;
  assign overflow   = r_overflow;

endmodule

// File: tb/tb_prog_loader.sv
// Scoreboard bench: two loaders (fill on / fill off) share one stream; expected writes
// are queued as words are driven and popped as each DUT issues them.
module tb_prog_loader;

  localparam int Depth = 64;

  logic       Clk = 1'b0;
  logic       Reset;
  logic       start;
  logic       in_valid;
  logic [8:0] in_word;
  logic       in_last;

  logic       f_in_ready, f_wr_en, f_core_reset, f_loaded, f_overflow;
  logic [5:0] f_wr_addr;
  logic [8:0] f_wr_data;
  logic [6:0] f_word_count;
  logic       n_in_ready, n_wr_en, n_core_reset, n_loaded, n_overflow;
  logic [5:0] n_wr_addr;
  logic [8:0] n_wr_data;
  logic [6:0] n_word_count;

  always #5 Clk = ~Clk;

  prog_loader #(.FILL_EN(1'b1)) u_dut_f (
    .Clk(Clk), .Reset(Reset), .start(start), .in_valid(in_valid), .in_word(in_word),
    .in_last(in_last), .in_ready(f_in_ready), .wr_en(f_wr_en), .wr_addr(f_wr_addr),
    .wr_data(f_wr_data), .core_reset(f_core_reset), .loaded(f_loaded),
    .word_count(f_word_count), .overflow(f_overflow)
  );

  prog_loader #(.FILL_EN(1'b0)) u_dut_n (
    .Clk(Clk), .Reset(Reset), .start(start), .in_valid(in_valid), .in_word(in_word),
    .in_last(in_last), .in_ready(n_in_ready), .wr_en(n_wr_en), .wr_addr(n_wr_addr),
    .wr_data(n_wr_data), .core_reset(n_core_reset), .loaded(n_loaded),
    .word_count(n_word_count), .overflow(n_overflow)
  );

  logic [14:0] q_f[$];
  logic [14:0] q_n[$];
  logic [8:0]  words[$];
  bit          vpat[$];
  int n_total = 0;
  int n_bad   = 0;
  int cyc_cnt = 0;
  int last_f  = 0;
  int last_n  = 0;
  logic prev_f = 1'b0;
  logic prev_n = 1'b0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_total++;
    if (obs !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h want %0h", tag, obs, exp);
    end
  endtask

  task automatic cyc();
    @(posedge Clk);
    #1;
  endtask

  // Write monitor: every write must match the head of its scoreboard queue.
  always @(negedge Clk) begin
    logic [14:0] e;
    cyc_cnt++;
    if (f_wr_en) begin
      if (q_f.size() == 0) check("wr_f_extra", 32'(f_wr_en), 32'(0));
      else begin
        e = q_f.pop_front();
        check("wr_f_addr", 32'(f_wr_addr), 32'(e[14:9]));
        check("wr_f_data", 32'(f_wr_data), 32'(e[8:0]));
      end
      last_f = cyc_cnt;
    end
    if (n_wr_en) begin
      if (q_n.size() == 0) check("wr_n_extra", 32'(n_wr_en), 32'(0));
      else begin
        e = q_n.pop_front();
        check("wr_n_addr", 32'(n_wr_addr), 32'(e[14:9]));
        check("wr_n_data", 32'(n_wr_data), 32'(e[8:0]));
      end
      last_n = cyc_cnt;
    end
    if (f_loaded && !prev_f) check("lat_f", 32'(cyc_cnt - last_f), 32'(1));
    if (n_loaded && !prev_n) check("lat_n", 32'(cyc_cnt - last_n), 32'(1));
    prev_f = f_loaded;
    prev_n = n_loaded;
  end

  task automatic run_load(input int n, input bit with_last, input bit start_in_gap,
                          input string tag);
    int   ma   = 0;
    int   acc  = 0;
    int   idx  = 0;
    int   pi   = 0;
    bit   done = 1'b0;
    bit   eovf = 1'b0;
    bit   v;
    bit   last;
    logic [8:0] w;
    start = 1'b1;
    cyc();
    start = 1'b0;
    check({tag, "_crst_f"}, 32'(f_core_reset), 32'(1));
    check({tag, "_crst_n"}, 32'(n_core_reset), 32'(1));
    check({tag, "_ld0_f"}, 32'(f_loaded), 32'(0));
    check({tag, "_ld0_n"}, 32'(n_loaded), 32'(0));
    for (int g = 0; g < 400 && idx < n; g++) begin
      v    = (pi < vpat.size()) ? vpat[pi] : 1'b1;
      pi++;
      w    = words[idx];
      last = with_last && (idx == n - 1);
      in_valid = v;
      in_word  = w;
      in_last  = last;
      start    = start_in_gap && !v;
      check({tag, "_rdy_f"}, 32'(f_in_ready), 32'(!done));
      check({tag, "_rdy_n"}, 32'(n_in_ready), 32'(!done));
      if (v && !done) begin
        q_f.push_back({6'(ma), w});
        q_n.push_back({6'(ma), w});
        acc++;
        if (last || ma == Depth - 1) begin
          done = 1'b1;
          eovf = !last;
          if (last && ma < Depth - 1)
            for (int a = ma + 1; a < Depth; a++) q_f.push_back({6'(a), 9'h000});
        end
        ma++;
      end
      if (v) idx++;
      cyc();
    end
    in_valid = 1'b0;
    in_last  = 1'b0;
    start    = 1'b0;
    for (int g = 0; g < 200 && !(f_loaded && n_loaded); g++) cyc();
    check({tag, "_loaded_f"}, 32'(f_loaded), 32'(1));
    check({tag, "_loaded_n"}, 32'(n_loaded), 32'(1));
    check({tag, "_crel_f"}, 32'(f_core_reset), 32'(0));
    check({tag, "_crel_n"}, 32'(n_core_reset), 32'(0));
    check({tag, "_wcnt_f"}, 32'(f_word_count), 32'(acc));
    check({tag, "_wcnt_n"}, 32'(n_word_count), 32'(acc));
    check({tag, "_ovf_f"}, 32'(f_overflow), 32'(eovf));
    check({tag, "_ovf_n"}, 32'(n_overflow), 32'(eovf));
    check({tag, "_qleft_f"}, 32'(q_f.size()), 32'(0));
    check({tag, "_qleft_n"}, 32'(q_n.size()), 32'(0));
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout want finish");
    $fatal(1, "watchdog");
  end

  initial begin
    Reset = 1'b1; start = 1'b0; in_valid = 1'b0; in_last = 1'b0; in_word = '0;
    #1;
    check("rst_rdy", 32'(f_in_ready), 32'(0));
    check("rst_wren", 32'(f_wr_en), 32'(0));
    check("rst_waddr", 32'(f_wr_addr), 32'(0));
    check("rst_wdata", 32'(f_wr_data), 32'(0));
    check("rst_crst", 32'(f_core_reset), 32'(1));
    check("rst_loaded", 32'(f_loaded), 32'(0));
    check("rst_wcnt", 32'(f_word_count), 32'(0));
    check("rst_ovf", 32'(f_overflow), 32'(0));
    check("rst_crst_n", 32'(n_core_reset), 32'(1));
    repeat (2) cyc();
    Reset = 1'b0;
    cyc();

    words = '{9'h0A1, 9'h0B2, 9'h1C3};
    run_load(3, 1'b1, 1'b0, "t1");

    words.delete();
    for (int i = 0; i < 70; i++) words.push_back(9'((i * 37 + 5) & 'h1FF));
    run_load(64, 1'b1, 1'b0, "t64");
    run_load(70, 1'b0, 1'b0, "t70");

    words = '{9'h011, 9'h022, 9'h033};
    vpat  = '{1'b1, 1'b0, 1'b0, 1'b1, 1'b1};
    run_load(3, 1'b1, 1'b1, "tgap");
    vpat.delete();

    // Abort a load with reset after five words.
    start = 1'b1;
    cyc();
    start = 1'b0;
    for (int i = 0; i < 5; i++) begin
      in_valid = 1'b1;
      in_word  = 9'(9'h100 + i);
      check("tr_rdy", 32'(f_in_ready), 32'(1));
      q_f.push_back({6'(i), in_word});
      q_n.push_back({6'(i), in_word});
      cyc();
    end
    in_valid = 1'b0;
    @(negedge Clk);
    #1;
    Reset = 1'b1;
    #1;
    check("tr_crst_f", 32'(f_core_reset), 32'(1));
    check("tr_crst_n", 32'(n_core_reset), 32'(1));
    check("tr_loaded_f", 32'(f_loaded), 32'(0));
    check("tr_wren_f", 32'(f_wr_en), 32'(0));
    check("tr_rdy_f", 32'(f_in_ready), 32'(0));
    check("tr_wcnt_f", 32'(f_word_count), 32'(0));
    check("tr_qleft_f", 32'(q_f.size()), 32'(0));
    check("tr_qleft_n", 32'(q_n.size()), 32'(0));
    cyc();
    Reset = 1'b0;
    cyc();
    words = '{9'h155, 9'h0AA, 9'h1FF};
    run_load(3, 1'b1, 1'b0, "t6");

    $display("test done: total=%0d bad=%0d", n_total, n_bad);
    $finish;
  end

endmodule

// File: doc/prog_loader.md
Name: prog_loader

Overview:
Streams 9-bit machine-code words from an external source (test bench, UART front end) into the instruction memory that the core's program counter fetches from.
- It is the write side of that memory; the core's fetch path is the read side.
- It holds the core in reset while loading.
- It pads unused locations with a fill word, then releases the core and flags completion.

Parameters:
IW, 9, instruction word width (matches mach_code)
AW, 6, address width (matches PC)
DEPTH, 64, number of instruction locations; must be <= 2**AW
FILL_EN, 1, 1 = pad addresses after the last loaded word with FILL_WORD
FILL_WORD, 9'h000, pad value written during fill

Ports:
Clk  in  1  system clock, rising edge
Reset  in  1  asynchronous, active-high
start  in  1  single-cycle pulse; begins a load
in_valid  in  1  source has a word on in_word
in_word  in  IW  machine-code word
in_last  in  1  qualifies in_word as final program word
in_ready  out  1  loader accepts a word this cycle
wr_en  out  1  instruction-memory write strobe
wr_addr  out  AW  instruction-memory write address
wr_data  out  IW  instruction-memory write data
core_reset  out  1  holds core (ProgCtr etc.) in reset
loaded  out  1  program present and core released
word_count  out  AW+1  number of stream words accepted in last load
overflow  out  1  stream exceeded DEPTH without in_last

Behaviour:
- Reset values:
  - state=IDLE
  - in_ready=0, wr_en=0, wr_addr=0, wr_data=0
  - core_reset=1, loaded=0, word_count=0, overflow=0
- States: IDLE, LOAD, FILL, DONE.
- IDLE:
  - start=1 -> LOAD; clear addr counter, word_count and overflow.
- LOAD:
  - in_ready=1 (combinational decode of state==LOAD); 0 in every other state.
  - Handshake = in_valid & in_ready.
  - On handshake in cycle N: wr_en=1, wr_addr=addr, wr_data=in_word, all registered and visible in cycle N+1. addr and word_count increment.
  - Handshake with in_last=1, or at addr==DEPTH-1:
    - Leave LOAD.
    - If FILL_EN and addr<DEPTH-1 -> FILL, else -> DONE.
  - Handshake at addr==DEPTH-1 with in_last=0:
    - overflow=1 (sticky until next start).
    - Go to DONE.
    - Later stream words are never accepted (in_ready=0).
- FILL:
  - One write per cycle of FILL_WORD at addr+1 … DEPTH-1.
  - After the DEPTH-1 write is issued -> DONE.
  - in_valid is ignored.
- DONE:
  - core_reset=0 and loaded=1, registered, asserted the cycle after the last wr_en cycle so the final write lands before fetch begins.
  - start=1 -> LOAD: core_reset=1 and loaded=0 next cycle; counters cleared.
- core_reset=1 in IDLE, LOAD and FILL.
- start is ignored in LOAD and FILL.
- wr_en is never asserted outside handshake/fill cycles; at most one write per cycle.
- Addresses wrap nowhere: the counter saturates at DEPTH-1 via the transitions above.
- Zero-length stream is impossible: the first accepted word is always written, even with in_last=1.
- Reset mid-LOAD/FILL: all outputs return to reset values immediately.
  - Memory contents already written are not cleared.
  - loaded stays 0 until a full new load completes.
- word_count counts stream words only, never fill writes. Range 1..DEPTH after a load.

Decomposition:
- Shared package: loader_state_t enum (IDLE, LOAD, FILL, DONE), IW/AW/DEPTH defaults, FILL_WORD default. The core top level uses the same package.
- No sub-module needed. The address counter and FSM live in one module, with one always_ff and one always_comb.

Test Plan:
- Reset, then start, then 3 words 9'h0A1, 9'h0B2, 9'h1C3 (last on third), FILL_EN=1:
  - Writes addr 0..2 with those values, then addr 3..63 with 9'h000.
  - loaded=1 and core_reset=0 one cycle after addr 63 write.
  - word_count=3, overflow=0.
- Same stream with FILL_EN=0:
  - Exactly 3 writes, DONE after addr 2.
  - No write to addr 3..63.
- 64 words, last on 64th:
  - Writes 0..63, no fill, overflow=0, word_count=64.
- 70 words, no last:
  - 64 writes accepted, in_ready=0 from word 65, overflow=1, loaded=1, word_count=64.
- in_valid toggling 1,0,0,1,1 with words 9'h011, 9'h022, 9'h033 (last):
  - Writes only on handshake cycles, addr 0,1,2 contiguous.
  - start pulses during LOAD have no effect.
- Reset asserted mid-LOAD after 5 words:
  - Immediately core_reset=1, loaded=0, wr_en=0, in_ready=0.
  - A new start then reloads from addr 0.
